// File: rtl/instr_encoder_pkg.sv
// ISA definitions shared by the instruction encoder: mnemonic codes, opcodes,
// Type A function codes, immediate bounds per format and word field positions.
package instr_encoder_pkg;

   typedef enum logic [4:0] {
      MN_ADD  = 5'd0,
      MN_SUB  = 5'd1,
      MN_AND  = 5'd2,
      MN_OR   = 5'd3,
      MN_MUL  = 5'd4,
      MN_DIV  = 5'd5,
      MN_SLL  = 5'd6,
      MN_SRL  = 5'd7,
      MN_ROL  = 5'd8,
      MN_ROR  = 5'd9,
      MN_ANDI = 5'd10,
      MN_ORI  = 5'd11,
      MN_LBU  = 5'd12,
      MN_SB   = 5'd13,
      MN_LW   = 5'd14,
      MN_SW   = 5'd15,
      MN_BGT  = 5'd16,
      MN_BLT  = 5'd17,
      MN_BEQ  = 5'd18,
      MN_JMP  = 5'd19,
      MN_HALT = 5'd20
   } mnem_e;

   // Opcodes (word bits 15:12)
   localparam logic [3:0] OP_A    = 4'b1111;
   localparam logic [3:0] OP_ANDI = 4'b1000;
   localparam logic [3:0] OP_ORI  = 4'b1001;
   localparam logic [3:0] OP_LBU  = 4'b1010;
   localparam logic [3:0] OP_SB   = 4'b1011;
   localparam logic [3:0] OP_LW   = 4'b1100;
   localparam logic [3:0] OP_SW   = 4'b1101;
   localparam logic [3:0] OP_BGT  = 4'b0100;
   localparam logic [3:0] OP_BLT  = 4'b0101;
   localparam logic [3:0] OP_BEQ  = 4'b0110;
   localparam logic [3:0] OP_JMP  = 4'b0001;
   localparam logic [3:0] OP_HALT = 4'b0000;

   // Type A function codes (word bits 3:0)
   localparam logic [3:0] FN_ADD = 4'b0000;
   localparam logic [3:0] FN_SUB = 4'b0001;
   localparam logic [3:0] FN_AND = 4'b0010;
   localparam logic [3:0] FN_OR  = 4'b0011;
   localparam logic [3:0] FN_MUL = 4'b0100;
   localparam logic [3:0] FN_DIV = 4'b0101;
   localparam logic [3:0] FN_SLL = 4'b1000;
   localparam logic [3:0] FN_SRL = 4'b1001;
   localparam logic [3:0] FN_ROL = 4'b1010;
   localparam logic [3:0] FN_ROR = 4'b1011;

   // Signed immediate bounds per format
   localparam logic signed [15:0] IMM_B_MIN = -16'sd8;
   localparam logic signed [15:0] IMM_B_MAX = 16'sd7;
   localparam logic signed [15:0] IMM_C_MIN = -16'sd128;
   localparam logic signed [15:0] IMM_C_MAX = 16'sd127;
   localparam logic signed [15:0] IMM_D_MIN = -16'sd2048;
   localparam logic signed [15:0] IMM_D_MAX = 16'sd2047;

   // Field positions inside the 16-bit instruction word
   localparam int OP_LSB = 12;
   localparam int R1_LSB = 8;
   localparam int R2_LSB = 4;

   function automatic logic [3:0] functOf(input logic [4:0] m);
      case (m)
         MN_ADD:  return FN_ADD;
         MN_SUB:  return FN_SUB;
         MN_AND:  return FN_AND;
         MN_OR:   return FN_OR;
         MN_MUL:  return FN_MUL;
         MN_DIV:  return FN_DIV;
         MN_SLL:  return FN_SLL;
         MN_SRL:  return FN_SRL;
         MN_ROL:  return FN_ROL;
         MN_ROR:  return FN_ROR;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] opcodeOf(input logic [4:0] m);
      case (m)
         MN_ANDI: return OP_ANDI;
         MN_ORI:  return OP_ORI;
         MN_LBU:  return OP_LBU;
         MN_SB:   return OP_SB;
         MN_LW:   return OP_LW;
         MN_SW:   return OP_SW;
         MN_BGT:  return OP_BGT;
         MN_BLT:  return OP_BLT;
         MN_BEQ:  return OP_BEQ;
         MN_JMP:  return OP_JMP;
         MN_HALT: return OP_HALT;
         default: return OP_A;
      endcase
   endfunction

   function automatic logic immInRange(input logic signed [15:0] v,
                                       input logic signed [15:0] lo,
                                       input logic signed [15:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request handshake and instruction-memory port of the instruction encoder.
// master = request producer / memory side, slave = the encoder.
interface instr_encoder_if #(
   parameter int AW = 8
);
   logic                 req_valid;
   logic                 req_ready;
   logic [4:0]           req_mnem;
   logic [3:0]           req_r1;
   logic [3:0]           req_r2;
   logic signed [15:0]   req_imm;
   logic                 imem_we;
   logic [AW-1:0]        imem_addr;
   logic [15:0]          imem_wdata;
   logic                 imem_re;
   logic [15:0]          imem_rdata;

   modport master (
      output req_valid, req_mnem, req_r1, req_r2, req_imm, imem_rdata,
      input  req_ready, imem_we, imem_addr, imem_wdata, imem_re
   );

   modport slave (
      input  req_valid, req_mnem, req_r1, req_r2, req_imm, imem_rdata,
      output req_ready, imem_we, imem_addr, imem_wdata, imem_re
   );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: mnemonic + register fields + signed immediate into the
// 16-bit instruction word, with a legal flag (known mnemonic, immediate in range).
module instr_encoder_pack
   import instr_encoder_pkg::*;
(
   input  logic [4:0]         mnem,
   input  logic [3:0]         r1,
   input  logic [3:0]         r2,
   input  logic signed [15:0] imm,
   output logic [15:0]        word,
   output logic               legal
);

   // Select the format from the mnemonic and range-check the immediate
   always_comb begin
      word  = 16'h0000;
      legal = 1'b0;
      case (mnem)
         MN_ADD, MN_SUB, MN_AND, MN_OR, MN_MUL,
         MN_DIV, MN_SLL, MN_SRL, MN_ROL, MN_ROR: begin
            word  = {OP_A, r1, r2, functOf(mnem)};
            legal = 1'b1;
         end
         MN_ANDI, MN_ORI, MN_LBU, MN_SB, MN_LW, MN_SW: begin
            word  = {opcodeOf(mnem), r1, r2, imm[3:0]};
            legal = immInRange(imm, IMM_B_MIN, IMM_B_MAX);
         end
         MN_BGT, MN_BLT, MN_BEQ: begin
            word  = {opcodeOf(mnem), r1, imm[7:0]};
            legal = immInRange(imm, IMM_C_MIN, IMM_C_MAX);
         end
         MN_JMP: begin
            word  = {OP_JMP, imm[11:0]};
            legal = immInRange(imm, IMM_D_MIN, IMM_D_MAX);
         end
         MN_HALT: begin
            // HALT carries no operand; the immediate is ignored
            word  = 16'h0000;
            legal = 1'b1;
         end
         default: begin
            word  = 16'h0000;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader. Accepts one symbolic instruction per
// handshake, encodes it and writes it to instruction memory at an
// auto-incrementing address that stops (full) after DEPTH words.
// Optional feature macro: READBACK_CHECK_EN adds a read-back-and-compare of
// every written word (RD/CMP states, imem_re, err_mismatch).
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           restart,
   instr_encoder_if.slave bus,
   output logic           err_illegal,
   output logic           err_mismatch,
   output logic           full
);

   typedef enum logic [2:0] {
`ifdef READBACK_CHECK_EN
      S_RD   = 3'd3,
      S_CMP  = 3'd4,
`endif
      S_IDLE = 3'd0,
      S_ENC  = 3'd1,
      S_WR   = 3'd2
   } state_e;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_e             state;
   state_e             nextState;
   logic [4:0]         reqMnem;
   logic [3:0]         reqR1;
   logic [3:0]         reqR2;
   logic signed [15:0] reqImm;
   logic [15:0]        packWord;
   logic               packLegal;
   logic [15:0]        wdataReg;
   logic [AW-1:0]      addrCnt;
   logic               fullReg;
   logic               errIllReg;
   logic               accept;
   logic               restartNow;
   logic               advance;

   assign bus.req_ready  = (state == S_IDLE) && !fullReg;
   // restart takes priority over a simultaneous request
   assign restartNow     = (state == S_IDLE) && restart;
   assign accept         = bus.req_ready && bus.req_valid && !restart;
   assign bus.imem_we    = (state == S_WR);
   assign bus.imem_addr  = addrCnt;
   assign bus.imem_wdata = wdataReg;
   assign err_illegal    = errIllReg;
   assign full           = fullReg;

`ifdef READBACK_CHECK_EN
   // Address stays on the written word until its read-back has been compared
   assign advance      = (state == S_CMP);
   assign bus.imem_re  = (state == S_RD);
   assign err_mismatch = (state == S_CMP) && (bus.imem_rdata != wdataReg);
`else
   logic unusedRdata;
   assign unusedRdata  = ^bus.imem_rdata;
   assign advance      = (state == S_WR);
   assign bus.imem_re  = 1'b0;
   assign err_mismatch = 1'b0;
`endif

   instr_encoder_pack u_pack (
      .mnem  (reqMnem),
      .r1    (reqR1),
      .r2    (reqR2),
      .imm   (reqImm),
      .word  (packWord),
      .legal (packLegal)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nextState;
   end

   // FSM next-state logic
   always_comb begin
      nextState = state;
      case (state)
         S_IDLE:  if (accept) nextState = S_ENC;
         S_ENC:   nextState = packLegal ? S_WR : S_IDLE;
`ifdef READBACK_CHECK_EN
         S_WR:    nextState = S_RD;
         S_RD:    nextState = S_CMP;
         S_CMP:   nextState = S_IDLE;
`else
         S_WR:    nextState = S_IDLE;
`endif
         default: nextState = S_IDLE;
      endcase
   end

   // Capture the request fields on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reqMnem <= '0;
         reqR1   <= '0;
         reqR2   <= '0;
         reqImm  <= '0;
      end else if (accept) begin
         reqMnem <= bus.req_mnem;
         reqR1   <= bus.req_r1;
         reqR2   <= bus.req_r2;
         reqImm  <= bus.req_imm;
      end
   end

   // Register the encoded word, or flag an illegal request, at the end of ENC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdataReg  <= '0;
         errIllReg <= 1'b0;
      end else begin
         errIllReg <= 1'b0;
         if (state == S_ENC) begin
            if (packLegal) wdataReg  <= packWord;
            else           errIllReg <= 1'b1;
         end
      end
   end

   // Write-address counter; saturates at the last word and raises full
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addrCnt <= '0;
         fullReg <= 1'b0;
      end else if (restartNow) begin
         addrCnt <= '0;
         fullReg <= 1'b0;
      end else if (advance) begin
         if (addrCnt == LAST_ADDR) fullReg <= 1'b1;
         else                      addrCnt <= addrCnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH=4): directed cases plus random
// requests compared against a behavioural encoder/loader model.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic restart = 1'b0;
   logic errIllegal;
   logic errMismatch;
   logic full;

   int nCompared = 0;
   int nMismatched = 0;

   // model state
   int expAddr = 0;
   bit expFull = 1'b0;
   logic [15:0] mem [DEPTH];

   int fnTab [10] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11};
   int opB   [6]  = '{8, 9, 10, 11, 12, 13};
   int opC   [3]  = '{4, 5, 6};
   int edgeImm [12] = '{-2049, -2048, 2047, 2048, -129, -128, 127, 128, -9, -8, 7, 8};

   instr_encoder_if #(.AW(AW)) bus ();

   instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .restart      (restart),
      .bus          (bus),
      .err_illegal  (errIllegal),
      .err_mismatch (errMismatch),
      .full         (full)
   );

   always #5 clk = ~clk;

   // Instruction memory model; read-back of address 0 returns bit 0 flipped
   always @(posedge clk) begin
      if (bus.imem_we) mem[bus.imem_addr] <= bus.imem_wdata;
      if (bus.imem_re)
         bus.imem_rdata <= mem[bus.imem_addr] ^ ((bus.imem_addr == '0) ? 16'h0001 : 16'h0000);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nCompared++;
      if (obs !== expv) begin
         nMismatched++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Behavioural encoder written from the format tables
   function automatic void refEncode(input int mn, input int r1, input int r2, input int imm,
                                     output bit legal, output int word);
      legal = 1'b0;
      word  = 0;
      if (mn >= int'(MN_ADD) && mn <= int'(MN_ROR)) begin
         legal = 1'b1;
         word  = 15 * 4096 + r1 * 256 + r2 * 16 + fnTab[mn];
      end else if (mn >= int'(MN_ANDI) && mn <= int'(MN_SW)) begin
         legal = (imm >= -8) && (imm <= 7);
         word  = opB[mn - int'(MN_ANDI)] * 4096 + r1 * 256 + r2 * 16 + ((imm + 16) % 16);
      end else if (mn >= int'(MN_BGT) && mn <= int'(MN_BEQ)) begin
         legal = (imm >= -128) && (imm <= 127);
         word  = opC[mn - int'(MN_BGT)] * 4096 + r1 * 256 + ((imm + 256) % 256);
      end else if (mn == int'(MN_JMP)) begin
         legal = (imm >= -2048) && (imm <= 2047);
         word  = 1 * 4096 + ((imm + 4096) % 4096);
      end else if (mn == int'(MN_HALT)) begin
         legal = 1'b1;
         word  = 0;
      end
   endfunction

   task automatic driveReq(input int mn, input int r1, input int r2, input int imm);
      bus.req_valid = 1'b1;
      bus.req_mnem  = 5'(mn);
      bus.req_r1    = 4'(r1);
      bus.req_r2    = 4'(r2);
      bus.req_imm   = 16'(imm);
   endtask

   // One request end to end; called and returns at a falling edge
   task automatic doReq(input int mn, input int r1, input int r2, input int imm);
      bit legal;
      int word;
      int waitCnt;
      refEncode(mn, r1, r2, imm, legal, word);
      waitCnt = 0;
      while (bus.req_ready !== 1'b1 && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      if (bus.req_ready !== 1'b1) begin
         checkEq("readyTimeout", 32'(bus.req_ready), 32'd1);
         return;
      end
      driveReq(mn, r1, r2, imm);
      @(negedge clk);                       // accepted at edge N
      bus.req_valid = 1'b0;
      checkEq("busyReady", 32'(bus.req_ready), 32'd0);
      checkEq("busyWe", 32'(bus.imem_we), 32'd0);
      @(negedge clk);                       // cycle N+2
      if (!legal) begin
         checkEq("illErr", 32'(errIllegal), 32'd1);
         checkEq("illWe", 32'(bus.imem_we), 32'd0);
         checkEq("illReady", 32'(bus.req_ready), 32'd1);
         checkEq("illAddr", 32'(bus.imem_addr), 32'(expAddr));
         @(negedge clk);
         checkEq("illErrPulse", 32'(errIllegal), 32'd0);
         return;
      end
      checkEq("wrWe", 32'(bus.imem_we), 32'd1);
      checkEq("wrAddr", 32'(bus.imem_addr), 32'(expAddr));
      checkEq("wrData", 32'(bus.imem_wdata), 32'(word));
      checkEq("wrErr", 32'(errIllegal), 32'd0);
      @(negedge clk);                       // cycle N+3
      checkEq("postWe", 32'(bus.imem_we), 32'd0);
`ifdef READBACK_CHECK_EN
      checkEq("rdRe", 32'(bus.imem_re), 32'd1);
      checkEq("rdAddr", 32'(bus.imem_addr), 32'(expAddr));
      @(negedge clk);                       // cycle N+4
      checkEq("cmpMismatch", 32'(errMismatch), 32'(expAddr == 0));
      checkEq("cmpReady", 32'(bus.req_ready), 32'd0);
      @(negedge clk);                       // cycle N+5
      checkEq("cmpPulse", 32'(errMismatch), 32'd0);
`else
      checkEq("noRe", 32'(bus.imem_re), 32'd0);
      checkEq("noMismatch", 32'(errMismatch), 32'd0);
`endif
      if (expAddr == DEPTH - 1) expFull = 1'b1;
      else                      expAddr++;
      checkEq("doneReady", 32'(bus.req_ready), 32'(!expFull));
      checkEq("doneFull", 32'(full), 32'(expFull));
      checkEq("doneAddr", 32'(bus.imem_addr), 32'(expAddr));
   endtask

   task automatic pulseRestart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      expAddr = 0;
      expFull = 1'b0;
      checkEq("rstrtFull", 32'(full), 32'd0);
      checkEq("rstrtAddr", 32'(bus.imem_addr), 32'd0);
      checkEq("rstrtReady", 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      int mn;
      int imm;
      bus.req_valid  = 1'b0;
      bus.req_mnem   = '0;
      bus.req_r1     = '0;
      bus.req_r2     = '0;
      bus.req_imm    = '0;
      bus.imem_rdata = '0;

      // reset values
      #12;
      checkEq("rstReady", 32'(bus.req_ready), 32'd1);
      checkEq("rstWe", 32'(bus.imem_we), 32'd0);
      checkEq("rstRe", 32'(bus.imem_re), 32'd0);
      checkEq("rstAddr", 32'(bus.imem_addr), 32'd0);
      checkEq("rstWdata", 32'(bus.imem_wdata), 32'd0);
      checkEq("rstErrIll", 32'(errIllegal), 32'd0);
      checkEq("rstErrMis", 32'(errMismatch), 32'd0);
      checkEq("rstFull", 32'(full), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // directed program filling the 4-word memory
      doReq(int'(MN_ADD), 1, 2, 0);
      checkEq("memAdd", 32'(mem[0]), 32'h0000F120);
      doReq(int'(MN_ORI), 3, 0, 5);
      checkEq("memOri", 32'(mem[1]), 32'h00009305);
      doReq(int'(MN_ORI), 3, 0, 8);
      doReq(int'(MN_BLT), 2, 0, -4);
      checkEq("memBlt", 32'(mem[2]), 32'h000052FC);
      doReq(int'(MN_JMP), 0, 0, 2048);
      doReq(int'(MN_JMP), 0, 0, 2047);
      checkEq("memJmp", 32'(mem[3]), 32'h000017FF);
      checkEq("fullFlag", 32'(full), 32'd1);
      checkEq("fullReady", 32'(bus.req_ready), 32'd0);
      checkEq("fullAddr", 32'(bus.imem_addr), 32'd3);

      // requests are refused while full
      driveReq(int'(MN_ADD), 4, 5, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkEq("fullNoWe", 32'(bus.imem_we), 32'd0);
         checkEq("fullHold", 32'(full), 32'd1);
      end
      bus.req_valid = 1'b0;
      pulseRestart();
      doReq(int'(MN_HALT), 0, 0, 1234);
      checkEq("memHalt", 32'(mem[0]), 32'h00000000);

      // restart and request in the same idle cycle: restart wins
      driveReq(int'(MN_SUB), 1, 1, 0);
      restart = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      restart = 1'b0;
      expAddr = 0;
      expFull = 1'b0;
      checkEq("rvReady", 32'(bus.req_ready), 32'd1);
      checkEq("rvAddr", 32'(bus.imem_addr), 32'd0);
      @(negedge clk);
      checkEq("rvNoWe", 32'(bus.imem_we), 32'd0);

      // asynchronous reset while the write strobe is high
      driveReq(int'(MN_MUL), 7, 8, 0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      checkEq("preRstWe", 32'(bus.imem_we), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkEq("asyncWe", 32'(bus.imem_we), 32'd0);
      checkEq("asyncAddr", 32'(bus.imem_addr), 32'd0);
      checkEq("asyncWdata", 32'(bus.imem_wdata), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      expAddr = 0;
      expFull = 1'b0;
      @(negedge clk);
      checkEq("relReady", 32'(bus.req_ready), 32'd1);
      doReq(int'(MN_ROR), 9, 10, 0);

      // random requests against the model
      for (int i = 0; i < 80; i++) begin
         if (expFull) pulseRestart();
         mn = int'($urandom_range(0, 23));
         case ($urandom_range(0, 3))
            0:       imm = int'($urandom_range(0, 20)) - 10;
            1:       imm = int'($urandom_range(0, 300)) - 150;
            2:       imm = int'($urandom_range(0, 4200)) - 2100;
            default: imm = edgeImm[$urandom_range(0, 11)];
         endcase
         doReq(mn, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), imm);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
